// File: rtl/binary_median_pkg.sv
// Shared definitions for the binary median stage: mode encodings and the
// parameter-derived widths and latency used by both RTL and testbench.
package binary_median_pkg;

    // Runtime filter modes selected by mode_in
    localparam logic [1:0] MODE_MEDIAN = 2'd0;
    localparam logic [1:0] MODE_ERODE  = 2'd1;
    localparam logic [1:0] MODE_DILATE = 2'd2;
    localparam logic [1:0] MODE_BYPASS = 2'd3;

    // Ceiling log2; clog2(WIN+1) bits hold a popcount of 0..WIN
    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Edges from a sample entering to its centred result on data_out:
    // half a window to reach the centre tap, one edge for the window
    // update and one for the registered decision.
    function automatic int lat_of(input int win);
        return (win - 1) / 2 + 2;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with synchronous clear, clocked on the
// falling edge like the rest of the camera pipeline.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift d through DEPTH stages; reset empties the whole line
    always_ff @(negedge clk) begin
        if (reset) begin
            // NOTE: this is a register chain, not a RAM, so every stage is
            // cleared; otherwise stale enables would leak out after reset.
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/binary_median_1xn.sv
// Horizontal 1xWIN binary morphology on one bit-plane of the camera stream.
// A running popcount over the last WIN samples of the current line drives a
// median/threshold, erode, dilate or bypass decision; the line qualifiers
// are delayed so every output describes the window's centre pixel.
// All registers update on the falling edge of clk to match the pipeline.
module binary_median_1xn
    import binary_median_pkg::*;
#(
    parameter  int WIN     = 15,
    parameter  int DATA_W  = 16,
    parameter  int BIT_SEL = 15,
    parameter  int HCNT_W  = 10,
    parameter  int PCNT_W  = 11,
    localparam int CW      = clog2(WIN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Cam_enable_in,
    input  logic [HCNT_W-1:0] CamHsync_count_in,
    input  logic [PCNT_W-1:0] CamPix_count_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CW-1:0]     thr_in,
    input  logic [1:0]        mode_in,
    output logic              Cam_enable_out,
    output logic [HCNT_W-1:0] CamHsync_count_out,
    output logic [PCNT_W-1:0] CamPix_count_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CW-1:0]     cnt_out
);

    localparam int          LAT    = lat_of(WIN);
    localparam int          CENTRE = (WIN - 1) / 2;
    localparam logic [CW-1:0] WIN_CW = CW'(WIN);

    // Sample and line-start detection
    logic          en_prev;
    logic          b;
    logic          ls;

    // Window state: w[0] is the newest sample, w[WIN-1] the oldest
    logic [WIN-1:0] w;
    logic [CW-1:0]  cnt;
    logic [CW:0]    cnt_sum;

    // Configuration latched during blanking
    logic [CW-1:0]  thr_q;
    logic [1:0]     mode_q;
    logic [CW-1:0]  thr_clamped;

    // Decision stage
    logic           decision;
    logic           dec_q;
    logic [CW-1:0]  cnt_q;
    logic           en_dly;

    // Only the selected bit plane is filtered and the popcount never carries
    // out; these bits are collected here so they read as deliberately unused.
    logic           unused_bits;
    assign unused_bits = ^{data_in, cnt_sum[CW]};

    // Blanking samples insert zeros; a rising enable marks a new line
    assign b  = data_in[BIT_SEL] & Cam_enable_in;
    assign ls = Cam_enable_in & ~en_prev;

    // One extra bit keeps the add-then-subtract from wrapping when cnt = WIN
    assign cnt_sum = {1'b0, cnt} + {{CW{1'b0}}, b} - {{CW{1'b0}}, w[WIN-1]};

    // Thresholds above WIN make median mode permanently output 0
    assign thr_clamped = (thr_in > WIN_CW) ? WIN_CW : thr_in;

    // Shift the window and keep its popcount; a line start clears history
    always_ff @(negedge clk) begin
        if (reset) begin
            en_prev <= 1'b0;
            w       <= '0;
            cnt     <= '0;
        end else begin
            // NOTE: non-blocking updates let w and cnt both see the previous
            // window, so the incremental count stays in step with the shift.
            en_prev <= Cam_enable_in;
            if (ls) begin
                w   <= {{(WIN-1){1'b0}}, b};
                cnt <= {{(CW-1){1'b0}}, b};
            end else begin
                w   <= {w[WIN-2:0], b};
                cnt <= CW'(cnt_sum);
            end
        end
    end

    // Accept new threshold and mode only while the pixel stream is blank
    always_ff @(negedge clk) begin
        if (reset) begin
            thr_q  <= CW'(CENTRE);
            mode_q <= MODE_MEDIAN;
        end else if (!Cam_enable_in) begin
            thr_q  <= thr_clamped;
            mode_q <= mode_in;
        end
    end

    // Per-mode decision from the current window
    always_comb begin
        // NOTE: default first so every path assigns decision and no latch forms.
        decision = 1'b0;
        case (mode_q)
            MODE_MEDIAN: decision = (cnt > thr_q);
            MODE_ERODE:  decision = (cnt == WIN_CW);
            MODE_DILATE: decision = (cnt != '0);
            default:     decision = w[CENTRE];
        endcase
    end

    // Register the decision and the popcount that produced it
    always_ff @(negedge clk) begin
        if (reset) begin
            dec_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            dec_q <= decision;
            cnt_q <= cnt;
        end
    end

    // Line qualifiers delayed to line up with the window centre
    pipe_delay #(.WIDTH(1), .DEPTH(LAT)) u_en_dly (
        .clk   (clk),
        .reset (reset),
        .d     (Cam_enable_in),
        .q     (en_dly)
    );

    pipe_delay #(.WIDTH(HCNT_W), .DEPTH(LAT)) u_hcnt_dly (
        .clk   (clk),
        .reset (reset),
        .d     (CamHsync_count_in),
        .q     (CamHsync_count_out)
    );

    pipe_delay #(.WIDTH(PCNT_W), .DEPTH(LAT)) u_pcnt_dly (
        .clk   (clk),
        .reset (reset),
        .d     (CamPix_count_in),
        .q     (CamPix_count_out)
    );

    assign Cam_enable_out = en_dly;
    assign data_out       = {DATA_W{dec_q & en_dly}};
    assign cnt_out        = cnt_q;

endmodule

// File: tb/tb_binary_median_1xn.sv
// Self-checking bench: a WIN=15 and a WIN=5 instance share one stimulus
// stream. The reference keeps a per-edge history of inputs and derives every
// expected output from window sums over that history.
module tb_binary_median_1xn;

    localparam int MAXE = 4096;
    localparam int WINS [2] = '{15, 5};
    localparam int LATS [2] = '{9, 4};

    typedef bit bitq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [9:0]  hcnt;
    logic [10:0] pcnt;
    logic [15:0] data;
    logic [3:0]  thr15;
    logic [2:0]  thr5;
    logic [1:0]  mode;

    logic        en_o15, en_o5;
    logic [9:0]  h_o15, h_o5;
    logic [10:0] p_o15, p_o5;
    logic [15:0] d_o15, d_o5;
    logic [3:0]  c_o15;
    logic [2:0]  c_o5;

    always #5 clk = ~clk;

    binary_median_1xn #(.WIN(15)) dut15 (
        .clk                (clk),
        .reset              (reset),
        .Cam_enable_in      (en),
        .CamHsync_count_in  (hcnt),
        .CamPix_count_in    (pcnt),
        .data_in            (data),
        .thr_in             (thr15),
        .mode_in            (mode),
        .Cam_enable_out     (en_o15),
        .CamHsync_count_out (h_o15),
        .CamPix_count_out   (p_o15),
        .data_out           (d_o15),
        .cnt_out            (c_o15)
    );

    binary_median_1xn #(.WIN(5)) dut5 (
        .clk                (clk),
        .reset              (reset),
        .Cam_enable_in      (en),
        .CamHsync_count_in  (hcnt),
        .CamPix_count_in    (pcnt),
        .data_in            (data),
        .thr_in             (thr5),
        .mode_in            (mode),
        .Cam_enable_out     (en_o5),
        .CamHsync_count_out (h_o5),
        .CamPix_count_out   (p_o5),
        .data_out           (d_o5),
        .cnt_out            (c_o5)
    );

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;

    // Per-edge input history and derived reference state
    bit rst_a [MAXE];
    bit en_a  [MAXE];
    bit b_a   [MAXE];
    int h_a   [MAXE];
    int p_a   [MAXE];
    int mode_a[MAXE];
    int hs_a  [2][MAXE];
    int thr_a [2][MAXE];

    // Observation statistics for directed expectations
    int hi_cnt [32];
    int lat15 = -1;
    int lat5 = -1;
    int mark = 0;
    int max15 = 0;
    int max5 = 0;
    int l9_cnt0 = 99;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n - 1, got, exp);
        end
    endtask

    // Ones among this line's samples inside the last WIN edges up to n
    function automatic int cnt_after(input int i, input int n);
        int lo;
        int s = 0;
        if (n < 0 || rst_a[n]) return 0;
        lo = hs_a[i][n];
        if (n - WINS[i] + 1 > lo) lo = n - WINS[i] + 1;
        for (int k = lo; k <= n; k++) s += int'(b_a[k]);
        return s;
    endfunction

    function automatic bit centre_after(input int i, input int n);
        int k;
        if (n < 0 || rst_a[n]) return 1'b0;
        k = n - (WINS[i] - 1) / 2;
        return (k >= hs_a[i][n] && k >= 0) ? b_a[k] : 1'b0;
    endfunction

    function automatic bit dec_after(input int i, input int n);
        int c;
        if (n < 1 || rst_a[n]) return 1'b0;
        c = cnt_after(i, n - 1);
        case (mode_a[n-1])
            0:       return c > thr_a[i][n-1];
            1:       return c == WINS[i];
            2:       return c != 0;
            default: return centre_after(i, n - 1);
        endcase
    endfunction

    // Input edge whose qualifiers appear at the delay output, or -1 if a
    // reset in between has emptied the delay line
    function automatic int dly_src(input int i, input int n);
        int k = n - LATS[i] + 1;
        if (k < 0) return -1;
        for (int j = k; j <= n; j++) if (rst_a[j]) return -1;
        return k;
    endfunction

    task automatic record();
        int n = edge_n;
        bit enp;
        bit ls;
        rst_a[n] = reset;
        en_a[n]  = en;
        b_a[n]   = data[15] & en;
        h_a[n]   = int'(hcnt);
        p_a[n]   = int'(pcnt);
        enp = (n > 0 && !rst_a[n-1]) ? en_a[n-1] : 1'b0;
        ls  = en && !enp;
        mode_a[n] = reset ? 0 : (!en ? int'(mode) : (n > 0 ? mode_a[n-1] : 0));
        for (int i = 0; i < 2; i++) begin
            int t;
            t = (i == 0) ? int'(thr15) : int'(thr5);
            if (t > WINS[i]) t = WINS[i];
            hs_a[i][n]  = reset ? n + 1 : (ls ? n : (n > 0 ? hs_a[i][n-1] : 0));
            thr_a[i][n] = reset ? (WINS[i] - 1) / 2 : (!en ? t : (n > 0 ? thr_a[i][n-1] : 0));
        end
        edge_n++;
    endtask

    task automatic compare_inst(input int i, input logic [15:0] dout, input int cnt,
                                input logic eno, input int ho, input int po);
        int n = edge_n - 1;
        int k = dly_src(i, n);
        bit e_exp = (k >= 0) ? en_a[k] : 1'b0;
        bit d_exp = dec_after(i, n) & e_exp;
        string s = (i == 0) ? "w15" : "w5";
        check({s, "_data_out"}, dout, d_exp ? 32'h0000_FFFF : 32'h0);
        check({s, "_cnt_out"}, cnt, rst_a[n] ? 0 : cnt_after(i, n - 1));
        check({s, "_en_out"}, eno, e_exp);
        check({s, "_hcnt_out"}, ho, (k >= 0) ? h_a[k] : 0);
        check({s, "_pcnt_out"}, po, (k >= 0) ? p_a[k] : 0);
    endtask

    task automatic compare();
        int n = edge_n - 1;
        compare_inst(0, d_o15, int'(c_o15), en_o15, int'(h_o15), int'(p_o15));
        compare_inst(1, d_o5, int'(c_o5), en_o5, int'(h_o5), int'(p_o5));
        if (int'(c_o15) > max15) max15 = int'(c_o15);
        if (int'(c_o5) > max5) max5 = int'(c_o5);
        if (rst_a[n]) begin
            mark  = n;
            lat15 = -1;
            lat5  = -1;
        end else begin
            if (lat15 < 0 && en_o15) lat15 = n - mark;
            if (lat5 < 0 && en_o5) lat5 = n - mark;
        end
        if (en_o15 && d_o15 == 16'hFFFF && h_o15 < 10'd32) hi_cnt[h_o15[4:0]]++;
        if (en_o15 && h_o15 == 10'd9 && p_o15 == 11'd0) l9_cnt0 = int'(c_o15);
    endtask

    // Drive one edge's inputs, let the DUT clock them, then compare mid-cycle
    task automatic step(input bit r, input bit e, input bit bv, input int h, input int p,
                        input int t15, input int t5, input int m);
        reset = r;
        en    = e;
        data  = 16'($urandom);
        if (e) data[15] = bv;
        hcnt  = 10'(h);
        pcnt  = 11'(p);
        thr15 = 4'(t15);
        thr5  = 3'(t5);
        mode  = 2'(m);
        @(negedge clk);
        record();
        @(posedge clk);
        #1;
        compare();
    endtask

    function automatic bitq_t make_run(input int len, input int s, input int r);
        bitq_t q;
        for (int k = 0; k < len; k++) q.push_back(k >= s && k < s + r);
        return q;
    endfunction

    function automatic bitq_t make_rand(input int len);
        bitq_t q;
        for (int k = 0; k < len; k++) q.push_back(1'($urandom));
        return q;
    endfunction

    // Blanking with the line's configuration, then the line with random
    // configuration inputs (which must be ignored), then flush blanking
    task automatic run_line(input int line, input bitq_t bits, input int pre, input int t15,
                            input int t5, input int m, input int post, input int rst_at);
        for (int k = 0; k < pre; k++)
            step(1'b0, 1'b0, 1'b0, line, int'($urandom_range(0, 2047)), t15, t5, m);
        for (int k = 0; k < bits.size(); k++) begin
            step(k == rst_at, 1'b1, bits[k], line, k, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            if (k == rst_at) begin
                check("rst_next_data_w15", d_o15, 0);
                check("rst_next_en_w15", en_o15, 0);
                check("rst_next_data_w5", d_o5, 0);
                check("rst_next_en_w5", en_o5, 0);
            end
        end
        for (int k = 0; k < post; k++)
            step(1'b0, 1'b0, 1'b0, line, int'($urandom_range(0, 2047)), t15, t5, m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        bitq_t q;
        int ones;
        for (int i = 0; i < 32; i++) hi_cnt[i] = 0;

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 7, 2, 0);
        check("reset_data_w15", d_o15, 0);
        check("reset_cnt_w15", c_o15, 0);

        // Line 0: all ones straight out of reset with the reset threshold
        run_line(0, make_run(20, 0, 20), 0, 7, 2, 0, 12, -1);
        check("l0_en_latency_w15", lat15, 9);
        check("l0_en_latency_w5", lat5, 4);
        check("l0_median_highs", hi_cnt[0], 20);

        run_line(1, make_run(30, 15, 1), 3, 7, 2, 0, 12, -1);
        check("l1_lone_one_highs", hi_cnt[1], 0);
        run_line(2, make_run(40, 10, 8), 3, 7, 2, 0, 12, -1);
        check("l2_run8_highs", hi_cnt[2], 8);
        run_line(3, make_run(40, 10, 20), 3, 7, 2, 1, 12, -1);
        check("l3_erode_highs", hi_cnt[3], 6);
        run_line(4, make_run(40, 20, 1), 3, 7, 2, 2, 12, -1);
        check("l4_dilate_highs", hi_cnt[4], 15);

        q = make_rand(40);
        ones = 0;
        foreach (q[k]) ones += int'(q[k]);
        run_line(5, q, 3, 7, 2, 3, 12, -1);
        check("l5_bypass_highs", hi_cnt[5], ones);

        // Threshold 7 keeps a run of 4 dark despite mid-line thr_in changes;
        // latching 3 in the next blanking lets the same run through
        run_line(6, make_run(40, 10, 4), 3, 7, 2, 0, 12, -1);
        check("l6_thr_held_highs", hi_cnt[6], 0);
        run_line(7, make_run(40, 15, 4), 3, 3, 1, 0, 12, -1);
        check("l7_thr3_run4_highs", hi_cnt[7], 12);

        // Line ending in ones, short gap, then an all-zero line
        run_line(8, make_run(30, 14, 16), 3, 7, 2, 0, 0, -1);
        run_line(9, make_run(30, 0, 0), 2, 7, 2, 0, 12, -1);
        check("l9_cleared_highs", hi_cnt[9], 0);
        check("l9_pixel0_cnt", l9_cnt0, 0);

        run_line(10, make_rand(30), 3, 7, 2, 0, 12, 10);
        check("rst_mid_latency_w15", lat15, 9);
        check("rst_mid_latency_w5", lat5, 4);

        for (int line = 11; line < 17; line++) begin
            run_line(line, make_rand(int'($urandom_range(20, 60))), int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), (line == 16) ? 12 : 0, -1);
        end

        check("cnt_max_w15", max15 <= 15, 1);
        check("cnt_max_w5", max5 <= 5, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
